fm_wb_arbiter: RTL and testbench
================================

FM_WB_ARBITER -- requirements
Module: fm_wb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 8, which is the number of PE-row write-back requesters (CONF_PE_ROW).
REQ-002 SHALL have parameter DW, default 8, which is the feature-map word width.
REQ-003 SHALL have parameter AW, default 10, which is the in-bank address width ($clog2(CONF_FM_BUF_DEPTH)-1).
REQ-004 SHALL have `clk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have `rst_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have `start`, input, 1: one-cycle pulse that latches the configuration and begins a write-back pass.
REQ-007 SHALL have `base_addr`, input, AW: offset of the first word of requester 0.
REQ-008 SHALL have `words_per_req`, input, AW: number of words each requester writes per pass.
REQ-009 SHALL have `ping_pong`, input, 1: bank select, latched at start.
REQ-010 SHALL have `busy`, output, 1: high while a pass is active.
REQ-011 SHALL have `done`, output, 1: one-cycle pulse at the end of a pass.
REQ-012 SHALL have `req_valid`, input, N_REQ: per-requester data valid.
REQ-013 SHALL have `req_data`, input, N_REQ x DW: per-requester write-back word.
REQ-014 SHALL have `req_ready`, output, N_REQ: one-hot grant.
REQ-015 SHALL have `req_finish`, output, N_REQ: requester k has written all its words.
REQ-016 SHALL have `load_wr_en`, input, 1; `load_wr_addr`, input, AW+1; `load_din`, input, DW: the external loader port.
REQ-017 SHALL have `mem_wr_en`, output, 1; `mem_wr_addr`, output, AW+1; `mem_din`, output, DW: the fm buffer write port.

Function
REQ-018 SHALL implement FSM states IDLE and RUN: IDLE->RUN on start; RUN->IDLE in the cycle after the last requester handshake.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL, on start with words_per_req=0, go directly to a done pulse in the next cycle with no memory writes, and SHALL remain in IDLE.
REQ-021 SHALL keep a per-requester counter cnt[k] of AW bits, cleared on start.
REQ-022 SHALL treat requester k as eligible in RUN when req_valid[k]=1 and cnt[k] != words_per_req.
REQ-023 SHALL grant at most one eligible requester per cycle, round-robin, starting the search at last_grant+1 mod N_REQ; last_grant resets to N_REQ-1.
REQ-024 SHALL drive req_ready combinationally from req_valid and the arbitration state; a handshake is req_valid[k] & req_ready[k].
REQ-025 SHALL give load_wr_en absolute priority: while it is high, req_ready=0 in every state and last_grant is held.
REQ-026 SHALL, on a handshake by k in cycle t, assert mem_wr_en in cycle t+1 with mem_din = req_data[k] and mem_wr_addr = {ping_pong_latched, (base_addr + k*words_per_req + cnt[k]) mod 2^AW}; cnt[k] then increments.
REQ-027 SHALL, on load_wr_en in cycle t, assert mem_wr_en in cycle t+1 with load_wr_addr and load_din passed through unchanged, in any state.
REQ-028 SHALL register all mem_* outputs; mem_wr_en is 0 in cycles with no source.
REQ-029 SHALL assert req_finish[k] when cnt[k] == words_per_req and hold it until the next start or reset.
REQ-030 SHALL pulse done for exactly one cycle, coincident with the mem_wr_en of the final requester word.
REQ-031 SHALL drive busy=1 from the cycle after start until and including the done cycle.
REQ-032 SHALL wrap address overflow silently mod 2^AW, with no error output.

Reset
REQ-033 SHALL, on rst_n low, asynchronously clear the FSM to IDLE and clear busy, done, req_ready, req_finish, mem_wr_en, mem_wr_addr, mem_din, every cnt[k] and the latched configuration.
REQ-034 SHALL abandon a pass interrupted by reset, with no done pulse and no pending write.

Structure
REQ-035 SHALL import N_REQ, DW and AW defaults from the shared package (CONF_PE_ROW, CONF_FM_BUF_DEPTH), together with the FSM state enum typedef.
REQ-036 SHALL use one sub-module, rr_arbiter (an N-input round-robin one-hot grant with hold input); everything else is flat.

Verification
REQ-037 SHALL cover: N_REQ=8, base=0, words=2, all valid held high -> grant order 0..7,0..7; addresses k*2+cnt; done with the 16th write; busy spans 17 cycles.
REQ-038 SHALL cover: load_wr_en high for 3 cycles mid-pass -> 3 load writes appear at t+1, req_ready=0 during those cycles, and the round-robin resumes at the held pointer.
REQ-039 SHALL cover: base=1020, words=4, AW=10, requester 1 -> addresses 1024..1027 wrap to 0..3 with bank bit = ping_pong.
REQ-040 SHALL cover: words=0 start -> done the next cycle, no mem_wr_en, busy never high.
REQ-041 SHALL cover: only requester 5 is valid with words=3 -> 3 consecutive grants, req_finish[5]=1 afterwards, pass not done until the others complete.
REQ-042 SHALL cover: rst_n dropped mid-pass -> all outputs 0 immediately; a new start runs a clean pass.

Source files
------------

// File: rtl/fm_wb_arbiter_pkg.sv
// Shared configuration and types for the feature-map write-back arbiter.
// Defaults track the PE array and feature-map buffer geometry.
package fm_wb_arbiter_pkg;

    localparam int CONF_PE_ROW       = 8;
    localparam int CONF_FM_DW        = 8;
    localparam int CONF_FM_BUF_DEPTH = 2048;
    localparam int FM_AW = $clog2(CONF_FM_BUF_DEPTH) - 1;

    typedef enum logic {
        IDLE,
        RUN
    } wb_state_t;

endpackage

// File: rtl/fm_wb_arbiter_rr.sv
// Round-robin one-hot grant; search starts one past the last winner.
// While hold is high nothing is granted and the pointer stays put.
module rr_arbiter
    import fm_wb_arbiter_pkg::*;
#(
    parameter int N = CONF_PE_ROW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         hold,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_q;
    logic [PW-1:0] last_d;
    logic [PW-1:0] idx;

    always_comb begin
        gnt    = '0;
        last_d = last_q;
        idx    = '0;
        if (!hold) begin
            for (int i = 1; i <= N; i++) begin
                idx = PW'((int'(last_q) + i) % N);
                if (req[idx] && gnt == '0) begin
                    gnt[idx] = 1'b1;
                    last_d   = idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fm_wb_arbiter.sv
// Merges PE-row write-back streams and the external loader into one
// registered feature-map buffer write port.
module fm_wb_arbiter
    import fm_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = CONF_PE_ROW,
    parameter int DW    = CONF_FM_DW,
    parameter int AW    = FM_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [AW-1:0]           base_addr,
    input  logic [AW-1:0]           words_per_req,
    input  logic                    ping_pong,
    output logic                    busy,
    output logic                    done,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0][DW-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        req_finish,
    input  logic                    load_wr_en,
    input  logic [AW:0]             load_wr_addr,
    input  logic [DW-1:0]           load_din,
    output logic                    mem_wr_en,
    output logic [AW:0]             mem_wr_addr,
    output logic [DW-1:0]           mem_din
);

    wb_state_t state_q, state_d;

    logic          busy_q, done_q, cfg_q, pp_q;
    logic [AW-1:0] base_q, wpr_q;
    logic [AW-1:0] cnt_q [N_REQ];

    logic [N_REQ-1:0] elig, hs, fin_now, fin_after;
    logic             start_ok, zero_start, last_hs;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;

    assign start_ok   = start & ~busy_q;
    assign zero_start = start_ok & (words_per_req == '0);
    assign hs         = req_valid & req_ready;
    assign last_hs    = (state_q == RUN) & (|hs) & (&fin_after);

    assign busy       = busy_q;
    assign done       = done_q;
    assign req_finish = cfg_q ? fin_now : '0;

    always_comb begin
        elig    = '0;
        fin_now = '0;
        for (int k = 0; k < N_REQ; k++) begin
            fin_now[k] = (cnt_q[k] == wpr_q);
            elig[k]    = (state_q == RUN) & req_valid[k] & ~fin_now[k];
        end
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (elig),
        .hold  (load_wr_en),
        .gnt   (req_ready)
    );

    // Requester k owns the slice starting at base + k*words, wrapping in-bank.
    always_comb begin
        fin_after = '0;
        wb_addr   = '0;
        wb_data   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            fin_after[k] = ((cnt_q[k] + AW'(hs[k])) == wpr_q);
            if (hs[k]) begin
                wb_addr = base_q + AW'(k) * wpr_q + cnt_q[k];
                wb_data = req_data[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok && !zero_start) state_d = RUN;
            RUN:     if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cfg_q  <= 1'b0;
            pp_q   <= 1'b0;
            base_q <= '0;
            wpr_q  <= '0;
            for (int k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
        end else begin
            done_q <= last_hs | zero_start;
            if (start_ok) begin
                cfg_q  <= 1'b1;
                pp_q   <= ping_pong;
                base_q <= base_addr;
                wpr_q  <= words_per_req;
                for (int k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
            end else begin
                for (int k = 0; k < N_REQ; k++)
                    if (hs[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
            end
            // busy covers the done cycle, then drops
            if (start_ok && !zero_start) busy_q <= 1'b1;
            else if (done_q)             busy_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_din     <= '0;
        end else if (load_wr_en) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= load_wr_addr;
            mem_din     <= load_din;
        end else if (|hs) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= {pp_q, wb_addr};
            mem_din     <= wb_data;
        end else begin
            mem_wr_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fm_wb_arbiter.sv
// Bench for fm_wb_arbiter: table of whole passes, directed corner
// sequences and random traffic against a behavioural reference model.
module tb_fm_wb_arbiter;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [AW-1:0]        base_addr = '0;
    logic [AW-1:0]        words_per_req = '0;
    logic                 ping_pong = 1'b0;
    logic                 busy, done;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0][DW-1:0] req_data = '0;
    logic [N-1:0]         req_ready, req_finish;
    logic                 load_wr_en = 1'b0;
    logic [AW:0]          load_wr_addr = '0;
    logic [DW-1:0]        load_din = '0;
    logic                 mem_wr_en;
    logic [AW:0]          mem_wr_addr;
    logic [DW-1:0]        mem_din;

    always #5 clk = ~clk;

    fm_wb_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .words_per_req (words_per_req),
        .ping_pong     (ping_pong),
        .busy          (busy),
        .done          (done),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .req_finish    (req_finish),
        .load_wr_en    (load_wr_en),
        .load_wr_addr  (load_wr_addr),
        .load_din      (load_din),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_din       (mem_din)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model state
    int m_cnt [N];
    int m_last, m_words, m_base;
    bit m_pp, m_cfg, m_active, m_busy, m_done, p_wen;
    int p_addr, p_din;

    logic [N-1:0] obs_rdy, obs_fin;
    logic         obs_done, obs_busy, obs_wen;
    logic [AW:0]  obs_addr;

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        m_last = N - 1;
        m_words = 0; m_base = 0; m_pp = 0;
        m_cfg = 0; m_active = 0; m_busy = 0; m_done = 0;
        p_wen = 0; p_addr = 0; p_din = 0;
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) req_data[k] = DW'($urandom);
    endtask

    // One clock: compare at negedge, advance model, return at posedge+1.
    task automatic cycle();
        int g, k;
        logic [N-1:0] exp_rdy, exp_fin;
        bit nb, dn, all;
        @(negedge clk);
        g = -1;
        exp_rdy = '0;
        if (m_active && !load_wr_en) begin
            for (int i = 1; i <= N; i++) begin
                k = (m_last + i) % N;
                if (g < 0 && req_valid[k] && m_cnt[k] != m_words) g = k;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        for (int j = 0; j < N; j++) exp_fin[j] = m_cfg && (m_cnt[j] == m_words);
        obs_rdy = req_ready; obs_fin = req_finish; obs_done = done;
        obs_busy = busy; obs_wen = mem_wr_en; obs_addr = mem_wr_addr;
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        chk("req_finish", int'(req_finish), int'(exp_fin));
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("mem_wr_en", int'(mem_wr_en), int'(p_wen));
        if (p_wen) begin
            chk("mem_wr_addr", int'(mem_wr_addr), p_addr);
            chk("mem_din", int'(mem_din), p_din);
        end
        nb = m_busy;
        dn = 0;
        if (m_done) nb = 0;
        if (load_wr_en) begin
            p_wen = 1; p_addr = int'(load_wr_addr); p_din = int'(load_din);
        end else if (g >= 0) begin
            p_wen = 1;
            p_addr = int'(m_pp) * 1024 + (m_base + g * m_words + m_cnt[g]) % 1024;
            p_din = int'(req_data[g]);
            m_cnt[g]++;
            m_last = g;
            all = 1;
            for (int j = 0; j < N; j++) if (m_cnt[j] != m_words) all = 0;
            if (all) begin m_active = 0; dn = 1; end
        end else begin
            p_wen = 0;
        end
        if (start && !m_busy) begin
            m_base = int'(base_addr); m_words = int'(words_per_req);
            m_pp = ping_pong; m_cfg = 1;
            for (int j = 0; j < N; j++) m_cnt[j] = 0;
            if (m_words == 0) dn = 1;
            else begin m_active = 1; nb = 1; end
        end
        m_busy = nb;
        m_done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_pass(input int b, input int w, input bit pp, input logic [N-1:0] v);
        base_addr = AW'(b); words_per_req = AW'(w); ping_pong = pp; req_valid = v;
        rand_data();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string name);
        for (int c = 0; c < 300; c++) begin
            rand_data();
            cycle();
            if (obs_done) break;
        end
        chk(name, int'(obs_done), 1);
    endtask

    task automatic run_pass(input int b, input int w, input bit pp, input logic [N-1:0] v,
                            output int nw, output int nbusy, output int first,
                            output int second, output int last);
        nw = 0; nbusy = 0; first = 0; second = 0; last = 0;
        begin_pass(b, w, pp, v);
        for (int c = 0; c < 300; c++) begin
            rand_data();
            cycle();
            if (obs_wen) begin
                if (nw == 0) first = int'(obs_addr);
                if (nw == 1) second = int'(obs_addr);
                last = int'(obs_addr);
                nw++;
            end
            if (obs_busy) nbusy++;
            if (obs_done) break;
        end
        chk("pass_done", int'(obs_done), 1);
    endtask

    typedef struct {
        int           base;
        int           words;
        bit           pp;
        logic [N-1:0] valid;
        int           writes;
        int           busy_cyc;
        int           first;
        int           second;
        int           last;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int nw, nb, fa, sa, la;

        tbl[0] = '{0,    2, 1'b0, 8'hff, 16, 17, 0,    2,    15};
        tbl[1] = '{1020, 4, 1'b1, 8'hff, 32, 33, 2044, 1024, 1051};
        tbl[2] = '{0,    0, 1'b0, 8'hff, 0,  0,  0,    0,    0};
        tbl[3] = '{5,    1, 1'b0, 8'hff, 8,  9,  5,    6,    12};

        model_reset();
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_finish", int'(req_finish), 0);
        chk("rst_wen", int'(mem_wr_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 4; t++) begin
            run_pass(tbl[t].base, tbl[t].words, tbl[t].pp, tbl[t].valid, nw, nb, fa, sa, la);
            chk($sformatf("tbl%0d_writes", t), nw, tbl[t].writes);
            chk($sformatf("tbl%0d_busy", t), nb, tbl[t].busy_cyc);
            chk($sformatf("tbl%0d_first", t), fa, tbl[t].first);
            chk($sformatf("tbl%0d_last", t), la, tbl[t].last);
            if (tbl[t].writes > 1) chk($sformatf("tbl%0d_second", t), sa, tbl[t].second);
        end

        // loader preempts the pass, pointer held
        begin_pass(0, 2, 1'b0, 8'hff);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rr_order", int'(obs_rdy), 1 << i);
        end
        for (int i = 0; i < 3; i++) begin
            load_wr_en = 1'b1;
            load_wr_addr = 11'(100 + i);
            load_din = 8'(8'ha0 + i);
            cycle();
            chk("load_ready", int'(obs_rdy), 0);
            if (i > 0) chk("load_addr", int'(obs_addr), 100 + i - 1);
        end
        load_wr_en = 1'b0;
        cycle();
        chk("resume_ready", int'(obs_rdy), 8'h08);
        chk("load_last", int'(obs_addr), 102);
        run_until_done("load_pass_done");

        // lone requester finishes early, pass waits for the rest
        begin_pass(0, 3, 1'b0, 8'h20);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lone_ready", int'(obs_rdy), 8'h20);
        end
        cycle();
        chk("lone_finish", int'(obs_fin), 8'h20);
        chk("lone_not_done", int'(obs_done), 0);
        chk("lone_busy", int'(obs_busy), 1);
        req_valid = 8'hff;
        run_until_done("lone_pass_done");

        // reset mid-pass
        begin_pass(0, 2, 1'b0, 8'hff);
        repeat (5) cycle();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_ready", int'(req_ready), 0);
        chk("mid_rst_finish", int'(req_finish), 0);
        chk("mid_rst_wen", int'(mem_wr_en), 0);
        chk("mid_rst_addr", int'(mem_wr_addr), 0);
        chk("mid_rst_din", int'(mem_din), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_pass(0, 2, 1'b0, 8'hff, nw, nb, fa, sa, la);
        chk("post_rst_writes", nw, 16);
        chk("post_rst_busy", nb, 17);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(5, 0) == 0);
            words_per_req = AW'($urandom_range(3, 0));
            base_addr = AW'($urandom);
            ping_pong = 1'($urandom);
            req_valid = N'($urandom);
            load_wr_en = ($urandom_range(7, 0) == 0);
            load_wr_addr = 11'($urandom);
            load_din = DW'($urandom);
            rand_data();
            cycle();
        end
        start = 1'b0;
        load_wr_en = 1'b0;
        req_valid = 8'hff;
        for (int c = 0; c < 100; c++) begin
            cycle();
            if (!obs_busy) break;
        end
        chk("drain_idle", int'(obs_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
